// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter merging NUM_REQ ready/valid streams into one registered output
// stream; a granted requester keeps the output until its last beat is accepted.
module rr_stream_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic                     clock_port,
    input  logic                     reset_port,
    input  logic                     clear,
    input  logic [NUM_REQ*WIDTH-1:0] in_data,
    input  logic [NUM_REQ-1:0]       in_last,
    input  logic [NUM_REQ-1:0]       in_valid,
    output logic [NUM_REQ-1:0]       in_ready,
    output logic [WIDTH-1:0]         output_port_data,
    output logic                     output_port_last,
    output logic [SEL_W-1:0]         output_port_sel,
    output logic                     output_port_valid,
    input  logic                     output_port_ready
);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   lock_idx_q, lock_idx_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_last_q;
    logic [SEL_W-1:0]   out_sel_q;

    logic [WIDTH-1:0]   data_arr [NUM_REQ];
    logic [SEL_W-1:0]   cand;
    logic [SEL_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               free;
    logic               accept;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign free   = ~out_valid_q | output_port_ready;
    assign accept = free & ~clear & grant_valid;

    // Output process: grant selection and per-requester ready.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        grant_valid = 1'b0;
        grant_idx   = lock_idx_q;
        cand        = '0;
        if (state_q == LOCKED) begin
            grant_valid = in_valid[lock_idx_q];
        end else begin
            // Scan downwards so the requester closest to ptr is the last (winning) assignment.
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                cand = SEL_W'((int'(ptr_q) + k) % NUM_REQ);
                if (in_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Reset gates ready combinationally so requesters see it drop the moment reset asserts.
    assign in_ready = (free & ~clear & ~reset_port & grant_valid)
                    ? (NUM_REQ'(1) << grant_idx) : '0;

    // Next-state process: packet lock and round-robin pointer.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        ptr_d      = ptr_q;
        if (accept) begin
            if (in_last[grant_idx]) begin
                state_d = IDLE;
                ptr_d   = (grant_idx == SEL_W'(NUM_REQ - 1)) ? '0 : grant_idx + SEL_W'(1);
            end else begin
                state_d    = LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    // State register plus the registered output beat.
    always_ff @(posedge clock_port or posedge reset_port) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_port) begin
            state_q     <= IDLE;
            lock_idx_q  <= '0;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
        end else if (clear) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_arr[grant_idx];
                out_last_q  <= in_last[grant_idx];
                out_sel_q   <= grant_idx;
            end else if (free) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign output_port_valid = out_valid_q;
    assign output_port_data  = out_data_q;
    assign output_port_last  = out_last_q;
    assign output_port_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: per-cycle vector table plus a mid-cycle reset sequence.
module tb_rr_stream_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;
    localparam int SEL_W   = 2;
    localparam int NV      = 29;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     clr;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_last;
    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ-1:0]       in_ready;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [SEL_W-1:0]         out_sel;
    logic                     out_valid;
    logic                     out_ready;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [31:0] data;
        logic        ready;
        logic        clr;
        logic [3:0]  exp_rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
        logic        exp_last;
    } vec_t;

    vec_t vecs [NV];

    rr_stream_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clock_port        (clk),
        .reset_port        (rst),
        .clear             (clr),
        .in_data           (in_data),
        .in_last           (in_last),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .output_port_data  (out_data),
        .output_port_last  (out_last),
        .output_port_sel   (out_sel),
        .output_port_valid (out_valid),
        .output_port_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // Round robin, single-beat packets
        vecs[0]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
        vecs[1]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'h2, 1'b1, 8'h11, 2'd1, 1'b1};
        vecs[2]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'h4, 1'b1, 8'h12, 2'd2, 1'b1};
        vecs[3]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'h8, 1'b1, 8'h13, 2'd3, 1'b1};
        vecs[4]  = '{4'hF, 4'hF, 32'h13121110, 1'b1, 1'b0, 4'h1, 1'b1, 8'h10, 2'd0, 1'b1};
        // Req1 three-beat packet with req0/req2 competing
        vecs[5]  = '{4'h7, 4'h5, 32'h0022A120, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA1, 2'd1, 1'b0};
        vecs[6]  = '{4'h7, 4'h5, 32'h0022A220, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA2, 2'd1, 1'b0};
        vecs[7]  = '{4'h7, 4'h7, 32'h0022A320, 1'b1, 1'b0, 4'h2, 1'b1, 8'hA3, 2'd1, 1'b1};
        vecs[8]  = '{4'h5, 4'h5, 32'h00220020, 1'b1, 1'b0, 4'h4, 1'b1, 8'h22, 2'd2, 1'b1};
        vecs[9]  = '{4'h1, 4'h1, 32'h00000020, 1'b1, 1'b0, 4'h1, 1'b1, 8'h20, 2'd0, 1'b1};
        vecs[10] = '{4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        // Backpressure: 5A held for five stalled cycles, then 6B follows directly
        vecs[11] = '{4'h2, 4'h2, 32'h00005A00, 1'b1, 1'b0, 4'h2, 1'b1, 8'h5A, 2'd1, 1'b1};
        for (int i = 12; i < 17; i++)
            vecs[i] = '{4'h4, 4'h4, 32'h006B0000, 1'b0, 1'b0, 4'h0, 1'b1, 8'h5A, 2'd1, 1'b1};
        vecs[17] = '{4'h4, 4'h4, 32'h006B0000, 1'b1, 1'b0, 4'h4, 1'b1, 8'h6B, 2'd2, 1'b1};
        vecs[18] = '{4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        // Locked owner req3 pauses; req0 must wait
        vecs[19] = '{4'h9, 4'h1, 32'h31000040, 1'b1, 1'b0, 4'h8, 1'b1, 8'h31, 2'd3, 1'b0};
        vecs[20] = '{4'h1, 4'h1, 32'h00000040, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[21] = '{4'h1, 4'h1, 32'h00000040, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[22] = '{4'h9, 4'h9, 32'h32000040, 1'b1, 1'b0, 4'h8, 1'b1, 8'h32, 2'd3, 1'b1};
        vecs[23] = '{4'h1, 4'h1, 32'h00000040, 1'b1, 1'b0, 4'h1, 1'b1, 8'h40, 2'd0, 1'b1};
        // Clear during req2 packet; afterwards ptr=0 so req0 wins
        vecs[24] = '{4'h4, 4'h0, 32'h00510000, 1'b1, 1'b0, 4'h4, 1'b1, 8'h51, 2'd2, 1'b0};
        vecs[25] = '{4'h5, 4'h1, 32'h00520060, 1'b1, 1'b1, 4'h0, 1'b0, 8'h00, 2'd0, 1'b0};
        vecs[26] = '{4'h5, 4'h1, 32'h00520060, 1'b1, 1'b0, 4'h1, 1'b1, 8'h60, 2'd0, 1'b1};
        vecs[27] = '{4'h4, 4'h0, 32'h00520000, 1'b1, 1'b0, 4'h4, 1'b1, 8'h52, 2'd2, 1'b0};
        vecs[28] = '{4'h4, 4'h4, 32'h00530000, 1'b1, 1'b0, 4'h4, 1'b1, 8'h53, 2'd2, 1'b1};

        rst       = 1'b1;
        clr       = 1'b0;
        in_data   = '0;
        in_last   = '0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #12;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_ready", 32'(in_ready), 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            in_valid  = vecs[i].valid;
            in_last   = vecs[i].last;
            in_data   = vecs[i].data;
            out_ready = vecs[i].ready;
            clr       = vecs[i].clr;
            #1;
            check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
                check($sformatf("v%0d_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
                check($sformatf("v%0d_last", i), 32'(out_last), 32'(vecs[i].exp_last));
            end
        end

        // Mid-cycle reset with beats pending; ptr is 3 after the table.
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = 32'h13121110;
        out_ready = 1'b1;
        clr       = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst_data", 32'(out_data), 32'h13);
        check("pre_rst_sel", 32'(out_sel), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_data", 32'(out_data), 32'h0);
        check("rst_last", 32'(out_last), 32'h0);
        check("rst_sel", 32'(out_sel), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_data", 32'(out_data), 32'h10);
        check("post_rst_sel", 32'(out_sel), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
